pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central sequencer for the five-stage pipeline's segment registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. It resolves load-use hazards, EX-stage branch redirects, multi-cycle data-memory waits with a timeout, and debug halt/single-step. It drives the en/stall/flush controls of every segment register and keeps saturating stall and flush statistics. Segment registers give flush priority over stall and hold when en=0.

## Interface
- MEM_TIMEOUT, 16: consecutive memory-stall cycles before ERROR (≥2)
- CNT_W, 32: width of statistics counters
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_is_load  in  1  instruction in EX is a load
- ex_rf_wa  in  5  destination register of the EX instruction
- id_rs0, id_rs1  in  5 each  source registers of the ID instruction
- id_rs0_used, id_rs1_used  in  1 each  source actually read
- ex_br_taken  in  1  EX redirects the PC (taken branch/jump)
- mem_req  in  1  MEM-stage instruction accesses dmem
- mem_ready  in  1  dmem access completes this cycle
- dbg_halt  in  1  level request to halt the front end
- dbg_step  in  1  one-cycle pulse that releases one fetch while halted
- seg_en  out  1  en for all four segment registers
- pc_stall  out  1  hold PC
- if_id_stall, if_id_flush  out  1 each
- id_ex_stall, id_ex_flush  out  1 each
- ex_mem_stall  out  1
- mem_wb_flush  out  1
- halted  out  1  state==HALT
- mem_err  out  1  state==ERROR (sticky)
- stall_cnt  out  CNT_W  cycles with pc_stall=1
- flush_cnt  out  CNT_W  cycles with ex_br_taken flush

## Operation
- States: RUN, MEM_WAIT, HALT, ERROR. Reset to RUN, wait_cnt=0, counters 0.
- The hazard terms are defined as follows:
  - memw = mem_req & ~mem_ready.
  - lu = ex_is_load & ex_rf_wa≠0 & ((id_rs0_used & id_rs0==ex_rf_wa) | (id_rs1_used & id_rs1==ex_rf_wa)).
- Output priority (RUN, MEM_WAIT, HALT). Outputs not listed are 0.
  1. memw: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall = 1; mem_wb_flush = 1.
  2. ex_br_taken: if_id_flush = 1 and id_ex_flush = 1. PC loads the target.
  3. lu: pc_stall, if_id_stall = 1; id_ex_flush = 1 (one bubble).
  4. HALT & ~dbg_step: pc_stall, if_id_stall = 1; id_ex_flush = 1. The back end drains.
  5. Otherwise all stall/flush outputs are 0.
- seg_en=1 except in ERROR. ERROR: seg_en=0, pc_stall=1, all flush=0; inputs ignored until rst.
- Transitions:
  - RUN/HALT with memw: go to MEM_WAIT, wait_cnt←1.
  - RUN & ~memw & dbg_halt: go to HALT.
  - HALT & ~memw & ~dbg_halt: go to RUN.
  - MEM_WAIT & memw: if wait_cnt==MEM_TIMEOUT−1, go to ERROR; else wait_cnt+1.
  - MEM_WAIT & ~memw: go to HALT if dbg_halt, else RUN. wait_cnt←0.
- dbg_step is ignored outside HALT. In HALT it applies rules 1–3 and 5 for that one cycle only.
- stall_cnt +1 each cycle pc_stall=1, including ERROR. flush_cnt +1 each cycle rule 2 fires. Both saturate at all-ones.

## Timing
- All stall/flush/seg_en outputs are combinational from the current state and inputs, valid in the same cycle. The segment registers act on them at the next edge.
- State, wait_cnt and counters update at posedge clk. halted and mem_err are registered (state decode).
- After rst with inputs idle: seg_en=1, every stall/flush output 0, halted=0, mem_err=0, counters 0.
- Load-use costs exactly 1 bubble. Branch costs 2 flushed slots. A memory wait of N cycles costs N frozen cycles plus N MEM/WB bubbles.
- The cycle mem_ready rises, the memory freeze is already released in that same cycle.
- ERROR is entered at the edge ending the MEM_TIMEOUT-th consecutive memw cycle.
- rst during MEM_WAIT/ERROR returns to RUN at that edge and clears wait_cnt and the counters.

## Test plan
- Load-use: ex_is_load=1, ex_rf_wa=5, id_rs1=5, id_rs1_used=1 for 1 cycle -> pc_stall=if_id_stall=id_ex_flush=1 for that cycle; stall_cnt=1.
- Branch and load-use together -> if_id_flush=id_ex_flush=1, pc_stall=0; flush_cnt=1, stall_cnt unchanged.
- Memory wait: mem_req=1 with mem_ready=0 for 3 cycles, then 1 -> 3 cycles of full freeze plus mem_wb_flush; 4th cycle all 0; state back to RUN; stall_cnt=3.
- Timeout with MEM_TIMEOUT=16: memw held 16 cycles -> mem_err=1 after the 16th edge, seg_en=0; rst -> mem_err=0, stall_cnt=0.
- Halt/step: dbg_halt=1 -> halted=1 next cycle with the front end frozen. One dbg_step pulse -> one cycle with pc_stall=0. Then dbg_halt=0 -> RUN.
- Reset mid-wait: rst asserted on 2nd memw cycle -> state RUN, wait_cnt=0. No ERROR after a subsequent 15-cycle wait.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central hazard sequencer for the five-stage pipeline.
// Drives en/stall/flush of the IF/ID, ID/EX, EX/MEM and MEM/WB segment
// registers and the PC. It handles load-use bubbles, EX branch redirects,
// dmem waits with a timeout into a sticky ERROR state, and debug halt/step.
// It also keeps saturating stall and flush statistics.
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_is_load,
   input  logic [4:0]       ex_rf_wa,
   input  logic [4:0]       id_rs0,
   input  logic [4:0]       id_rs1,
   input  logic             id_rs0_used,
   input  logic             id_rs1_used,
   input  logic             ex_br_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             dbg_halt,
   input  logic             dbg_step,
   output logic             seg_en,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_stall,
   output logic             id_ex_flush,
   output logic             ex_mem_stall,
   output logic             mem_wb_flush,
   output logic             halted,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // MEM_TIMEOUT-1 is the largest value wait_cnt ever has to hold.
   localparam int WCW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

   typedef enum logic [1:0] {RUN, MEM_WAIT, HALT, ERROR} state_t;

   state_t         state, state_nxt;
   logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
   logic           memw, lu, br_flush;

   assign memw = mem_req & ~mem_ready;
   assign lu   = ex_is_load & (ex_rf_wa != 5'd0) &
                 ((id_rs0_used & (id_rs0 == ex_rf_wa)) |
                  (id_rs1_used & (id_rs1 == ex_rf_wa)));

   // halted and mem_err are decodes of the state register, so they
   // change only at a clock edge.
   assign halted  = (state == HALT);
   assign mem_err = (state == ERROR);

   // State and wait counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // Next-state logic; memw wins over halt/resume requests
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      unique case (state)
         RUN: begin
            if (memw) begin
               state_nxt    = MEM_WAIT;
               wait_cnt_nxt = WCW'(1);
            end else if (dbg_halt) begin
               state_nxt = HALT;
            end
         end
         MEM_WAIT: begin
            if (memw) begin
               if (wait_cnt == WCW'(MEM_TIMEOUT - 1)) state_nxt = ERROR;
               else wait_cnt_nxt = wait_cnt + WCW'(1);
            end else begin
               state_nxt    = dbg_halt ? HALT : RUN;
               wait_cnt_nxt = '0;
            end
         end
         HALT: begin
            if (memw) begin
               state_nxt    = MEM_WAIT;
               wait_cnt_nxt = WCW'(1);
            end else if (!dbg_halt) begin
               state_nxt = RUN;
            end
         end
         ERROR: state_nxt = ERROR;
         default: state_nxt = RUN;
      endcase
   end

   // Segment control outputs, evaluated in priority order
   always_comb begin
      seg_en       = 1'b1;
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_stall  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_stall = 1'b0;
      mem_wb_flush = 1'b0;
      br_flush     = 1'b0;
      if (state == ERROR) begin
         // The whole pipe freezes; only a reset leaves this state.
         seg_en   = 1'b0;
         pc_stall = 1'b1;
      end else if (memw) begin
         // Freeze everything up to MEM and feed bubbles into WB.
         pc_stall     = 1'b1;
         if_id_stall  = 1'b1;
         id_ex_stall  = 1'b1;
         ex_mem_stall = 1'b1;
         mem_wb_flush = 1'b1;
      end else if (ex_br_taken) begin
         // Kill the two younger slots; the PC loads the target.
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         br_flush    = 1'b1;
      end else if (lu || (state == HALT && !dbg_step)) begin
         // Hold the front end and insert one bubble into EX. While
         // halted, this also lets the back end drain.
         pc_stall    = 1'b1;
         if_id_stall = 1'b1;
         id_ex_flush = 1'b1;
      end
   end

   // Saturating statistics counters
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (pc_stall && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + CNT_W'(1);
         if (br_flush && flush_cnt != {CNT_W{1'b1}}) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. It uses a narrow counter width so
// that counter saturation can be reached inside the timeout scenario.
module tb_pipe_hazard_ctrl;

   localparam int MT = 16;
   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          ex_is_load, id_rs0_used, id_rs1_used;
   logic [4:0]    ex_rf_wa, id_rs0, id_rs1;
   logic          ex_br_taken, mem_req, mem_ready, dbg_halt, dbg_step;
   logic          seg_en, pc_stall, if_id_stall, if_id_flush;
   logic          id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush;
   logic          halted, mem_err;
   logic [CW-1:0] stall_cnt, flush_cnt;
   logic [7:0]    ctl;

   int ntot = 0;
   int npass = 0;

   // Bit order: seg_en pc_stall if_id_stall if_id_flush id_ex_stall id_ex_flush ex_mem_stall mem_wb_flush
   assign ctl = {seg_en, pc_stall, if_id_stall, if_id_flush,
                 id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush};

   localparam logic [7:0] C_IDLE  = 8'b1000_0000;
   localparam logic [7:0] C_LU    = 8'b1110_0100;
   localparam logic [7:0] C_BR    = 8'b1001_0100;
   localparam logic [7:0] C_MEMW  = 8'b1110_1011;
   localparam logic [7:0] C_ERR   = 8'b0100_0000;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .ex_is_load(ex_is_load), .ex_rf_wa(ex_rf_wa),
      .id_rs0(id_rs0), .id_rs1(id_rs1),
      .id_rs0_used(id_rs0_used), .id_rs1_used(id_rs1_used),
      .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .dbg_halt(dbg_halt), .dbg_step(dbg_step),
      .seg_en(seg_en), .pc_stall(pc_stall),
      .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
      .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
      .ex_mem_stall(ex_mem_stall), .mem_wb_flush(mem_wb_flush),
      .halted(halted), .mem_err(mem_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic idle_inputs();
      ex_is_load = 0; ex_rf_wa = 0; id_rs0 = 0; id_rs1 = 0;
      id_rs0_used = 0; id_rs1_used = 0; ex_br_taken = 0;
      mem_req = 0; mem_ready = 0; dbg_halt = 0; dbg_step = 0;
   endtask

   // Advance one clock; inputs change 1 time unit after the edge
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      tick();
      tick();
      rst = 0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      ntot++; if (ctl !== C_IDLE) $display("FAIL reset_ctl: got %b want %b", ctl, C_IDLE); else npass++;
      ntot++; if ({halted, mem_err} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {halted, mem_err}); else npass++;
      ntot++; if (stall_cnt !== 0 || flush_cnt !== 0) $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); else npass++;
   endtask

   task automatic test_load_use();
      do_reset();
      ex_is_load = 1; ex_rf_wa = 5; id_rs1 = 5; id_rs1_used = 1;
      #1;
      ntot++; if (ctl !== C_LU) $display("FAIL lu_ctl: got %b want %b", ctl, C_LU); else npass++;
      tick();
      // Matching register on a source that is not read: no hazard
      id_rs1_used = 0; id_rs0 = 5; id_rs0_used = 0;
      #1;
      ntot++; if (ctl !== C_IDLE) $display("FAIL lu_unused: got %b want %b", ctl, C_IDLE); else npass++;
      ntot++; if (stall_cnt !== 1) $display("FAIL lu_cnt: got %0d want 1", stall_cnt); else npass++;
      // A load to x0 never creates a hazard
      ex_rf_wa = 0; id_rs0 = 0; id_rs0_used = 1;
      #1;
      ntot++; if (ctl !== C_IDLE) $display("FAIL lu_x0: got %b want %b", ctl, C_IDLE); else npass++;
      // A hazard on rs0 stalls
      ex_rf_wa = 7; id_rs0 = 7;
      #1;
      ntot++; if (ctl !== C_LU) $display("FAIL lu_rs0: got %b want %b", ctl, C_LU); else npass++;
      tick();
      idle_inputs();
   endtask

   task automatic test_branch();
      do_reset();
      ex_br_taken = 1; ex_is_load = 1; ex_rf_wa = 5; id_rs1 = 5; id_rs1_used = 1;
      #1;
      ntot++; if (ctl !== C_BR) $display("FAIL br_ctl: got %b want %b", ctl, C_BR); else npass++;
      tick();
      idle_inputs();
      #1;
      ntot++; if (flush_cnt !== 1 || stall_cnt !== 0) $display("FAIL br_cnt: got %0d/%0d want 1/0", flush_cnt, stall_cnt); else npass++;
   endtask

   task automatic test_mem_wait();
      do_reset();
      mem_req = 1; mem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         ntot++; if (ctl !== C_MEMW) $display("FAIL memw_ctl%0d: got %b want %b", i, ctl, C_MEMW); else npass++;
         tick();
      end
      // The cycle ready rises the freeze is already released, even with a branch pending
      mem_ready = 1; ex_br_taken = 1;
      #1;
      ntot++; if (ctl !== C_BR) $display("FAIL memw_release: got %b want %b", ctl, C_BR); else npass++;
      tick();
      idle_inputs();
      #1;
      ntot++; if (ctl !== C_IDLE || halted !== 0 || mem_err !== 0) $display("FAIL memw_after: got %b/%b%b want %b/00", ctl, halted, mem_err, C_IDLE); else npass++;
      ntot++; if (stall_cnt !== 3 || flush_cnt !== 1) $display("FAIL memw_cnt: got %0d/%0d want 3/1", stall_cnt, flush_cnt); else npass++;
   endtask

   task automatic test_timeout();
      do_reset();
      mem_req = 1; mem_ready = 0;
      for (int i = 1; i <= MT - 1; i++) tick();
      #1;
      ntot++; if (mem_err !== 0 || ctl !== C_MEMW) $display("FAIL to_early: got %b/%b want 0/%b", mem_err, ctl, C_MEMW); else npass++;
      tick();
      // ERROR ignores every input, including a branch
      mem_req = 0; ex_br_taken = 1; dbg_halt = 1;
      #1;
      ntot++; if (mem_err !== 1 || ctl !== C_ERR) $display("FAIL to_err: got %b/%b want 1/%b", mem_err, ctl, C_ERR); else npass++;
      ntot++; if (stall_cnt !== 16) $display("FAIL to_cnt: got %0d want 16", stall_cnt); else npass++;
      // 20 more frozen cycles saturate the 5-bit counter at 31
      for (int i = 0; i < 20; i++) tick();
      #1;
      ntot++; if (stall_cnt !== 31 || flush_cnt !== 0 || mem_err !== 1) $display("FAIL to_sat: got %0d/%0d/%b want 31/0/1", stall_cnt, flush_cnt, mem_err); else npass++;
      do_reset();
      #1;
      ntot++; if (mem_err !== 0 || stall_cnt !== 0 || ctl !== C_IDLE) $display("FAIL to_rst: got %b/%0d/%b want 0/0/%b", mem_err, stall_cnt, ctl, C_IDLE); else npass++;
   endtask

   task automatic test_halt_step();
      do_reset();
      dbg_halt = 1;
      #1;
      ntot++; if (ctl !== C_IDLE || halted !== 0) $display("FAIL halt_req: got %b/%b want %b/0", ctl, halted, C_IDLE); else npass++;
      tick();
      #1;
      ntot++; if (ctl !== C_LU || halted !== 1) $display("FAIL halt_frz: got %b/%b want %b/1", ctl, halted, C_LU); else npass++;
      tick();
      dbg_step = 1;
      #1;
      ntot++; if (ctl !== C_IDLE) $display("FAIL halt_step: got %b want %b", ctl, C_IDLE); else npass++;
      tick();
      dbg_step = 0; dbg_halt = 0;
      #1;
      ntot++; if (ctl !== C_LU || halted !== 1) $display("FAIL halt_refrz: got %b/%b want %b/1", ctl, halted, C_LU); else npass++;
      tick();
      #1;
      ntot++; if (ctl !== C_IDLE || halted !== 0) $display("FAIL halt_run: got %b/%b want %b/0", ctl, halted, C_IDLE); else npass++;
      ntot++; if (stall_cnt !== 2) $display("FAIL halt_cnt: got %0d want 2", stall_cnt); else npass++;
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      mem_req = 1; mem_ready = 0;
      tick();
      rst = 1;
      tick();
      rst = 0;
      // memw stays asserted: a fresh wait of 15 cycles must not time out
      for (int i = 0; i < MT - 1; i++) tick();
      #1;
      ntot++; if (mem_err !== 0 || ctl !== C_MEMW) $display("FAIL rmw_noerr: got %b/%b want 0/%b", mem_err, ctl, C_MEMW); else npass++;
      ntot++; if (stall_cnt !== 15) $display("FAIL rmw_cnt: got %0d want 15", stall_cnt); else npass++;
      mem_ready = 1;
      tick();
      idle_inputs();
      #1;
      ntot++; if (mem_err !== 0 || halted !== 0 || ctl !== C_IDLE) $display("FAIL rmw_end: got %b%b/%b want 00/%b", mem_err, halted, ctl, C_IDLE); else npass++;
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_timeout();
      test_halt_step();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
